div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have CLK, input, 1, rising-edge clock for all state.
REQ-002 SHALL have RST, input, 1; reset RST, synchronous, active-high; clock CLK.
REQ-003 SHALL have SIGNED_DIV, input, 1: 1 = two's-complement divide, 0 = unsigned; sampled with START.
REQ-004 SHALL have DIVIDEND, input, 32, numerator; sampled with START.
REQ-005 SHALL have DIVISOR, input, 32, denominator; sampled with START.
REQ-006 SHALL have START, input, 1: request a division; honoured only in state FREE.
REQ-007 SHALL have CANCEL, input, 1: abort the operation in flight (pipeline flush).
REQ-008 SHALL have RESULT, output, 64: {remainder[63:32] (HI), quotient[31:0] (LO)}, registered.
REQ-009 SHALL have READY, output, 1: one-cycle pulse marking RESULT valid.

Function
REQ-010 SHALL have states FREE, BY_ZERO, ON and END; encodings in the shared package.
REQ-011 FREE: START=1 and CANCEL=0 latch the operands, the mode and the operand signs; DIVISOR=0 selects BY_ZERO, otherwise ON with iteration counter 0.
REQ-012 ON SHALL perform one restoring step per cycle on the magnitudes: shift {rem,quo} left by 1, trial-subtract the 33-bit divisor, and keep the difference with quotient bit 1 when there is no borrow.
REQ-013 ON SHALL move to END after exactly 32 steps (counter 0..31).
REQ-014 Latency: READY SHALL be high in the cycle after the 33rd rising edge that follows the edge sampling START.
REQ-015 END SHALL set READY=1 for exactly one cycle, load RESULT, and return to FREE on the next edge.
REQ-016 Sign fix in END, signed mode only: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no exception.
REQ-018 CANCEL=1 in ON, BY_ZERO or END SHALL force FREE on the next edge with READY=0 and RESULT unchanged.
REQ-019 CANCEL SHALL take priority over START in the same cycle.
REQ-020 START while not in FREE SHALL be ignored; operands held internally are unaffected.
REQ-021 RESULT SHALL hold its last value until the next END load.

Reset
REQ-022 RST=1 SHALL force state FREE, counter 0, READY 0, RESULT 0 and all internal operand registers 0 at the next edge, including in the middle of an operation.
REQ-023 RST SHALL override START and CANCEL.

Configuration
REQ-024 With DIV_ZERO_FAST_EN defined: BY_ZERO SHALL go to END on the next edge, RESULT=0, and READY high in the cycle after the 2nd edge following START.
REQ-025 Without DIV_ZERO_FAST_EN: a zero divisor SHALL take the normal 32-step ON path with the REQ-014 latency; the RESULT value is MIPS UNPREDICTABLE and is not checked. BY_ZERO is unreachable.

Structure
REQ-026 The package SHALL hold the state typedef div_state_t, DIV_ITER=32, and the operand/result widths.
REQ-027 SHALL contain one sub-module, div_step: a combinational single restoring iteration (33-bit trial subtract plus shift) taking {rem,quo,divisor} and returning the next {rem,quo}.
REQ-028 SHALL mirror the multiplier's START/CANCEL/READY handshake so the EX stage drives both units identically.

Verification
REQ-029 Unsigned 100/7 -> READY after 33 edges, RESULT={0x00000002,0x0000000E}.
REQ-030 Signed -7/2 (0xFFFFFFF9/0x00000002) -> RESULT={0xFFFFFFFF,0xFFFFFFFD}; unsigned 0xFFFFFFFF/1 -> {0,0xFFFFFFFF}.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> RESULT={0x00000000,0x80000000}.
REQ-032 CANCEL at step 10 -> READY never pulses, RESULT unchanged; an immediate new START 9/3 -> {0,3} at the normal latency.
REQ-033 DIV_ZERO_FAST_EN defined, 5/0 -> READY after 2 edges, RESULT=0; START held high during ON -> ignored, exactly one READY pulse.
REQ-034 RST at step 20 -> FREE, READY 0, RESULT 0 next edge; no stale READY later.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative divider.
//   div_state_t : FSM state encoding (FREE, BY_ZERO, ON, END)
//   DIV_W       : operand width
//   RES_W       : result width, {remainder, quotient}
//   DIV_ITER    : restoring steps per division
//   CNT_W       : width of the step counter
//   abs_val()   : conditional two's-complement magnitude
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W    = 32;
    localparam int RES_W    = 2 * DIV_W;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_t;

    // Negates v when neg is set. 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude of the most negative operand.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if -- request/response bundle between the EX stage and the divider.
// Same START/CANCEL/READY handshake as the multiplier.
//   SIGNED_DIV : 1 = two's-complement divide, 0 = unsigned (sampled with START)
//   DIVIDEND   : numerator   (sampled with START)
//   DIVISOR    : denominator (sampled with START)
//   START      : request a division
//   CANCEL     : abort the operation in flight
//   RESULT     : {remainder, quotient}, registered
//   READY      : one-cycle pulse marking RESULT valid
// Modports: master = EX stage side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_if;
    import div_pkg::*;

    logic             SIGNED_DIV;
    logic [DIV_W-1:0] DIVIDEND;
    logic [DIV_W-1:0] DIVISOR;
    logic             START;
    logic             CANCEL;
    logic [RES_W-1:0] RESULT;
    logic             READY;

    modport master (
        output SIGNED_DIV, DIVIDEND, DIVISOR, START, CANCEL,
        input  RESULT, READY
    );

    modport slave (
        input  SIGNED_DIV, DIVIDEND, DIVISOR, START, CANCEL,
        output RESULT, READY
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one combinational restoring-division iteration on magnitudes.
//   rem_i, quo_i : current partial remainder / shifting quotient
//   dvs_i        : divisor magnitude
//   rem_o, quo_o : values after shifting {rem,quo} left by one and
//                  trial-subtracting the divisor
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quo_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quo_o
);

    logic [DIV_W:0]   rem_sh;
    logic [DIV_W+1:0] trial;
    logic             borrow;
    logic             trial_msb_unused;

    // 33-bit shifted remainder: the quotient MSB moves into the remainder.
    assign rem_sh = {rem_i, quo_i[DIV_W-1]};
    // Extra guard bit so the borrow is simply the sign of the difference.
    assign trial  = {1'b0, rem_sh} - {2'b00, dvs_i};
    assign borrow = trial[DIV_W+1];

    // The remainder stays below the divisor, so a successful difference
    // always fits in DIV_W bits; bit DIV_W of the difference is never needed.
    assign trial_msb_unused = trial[DIV_W];

    assign rem_o = borrow ? rem_sh[DIV_W-1:0] : trial[DIV_W-1:0];
    assign quo_o = {quo_i[DIV_W-2:0], ~borrow};

endmodule

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit iterative restoring divider (signed/unsigned), one bit/cycle.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous, active-high reset
//   bus : div_if.slave (SIGNED_DIV, DIVIDEND, DIVISOR, START, CANCEL in;
//         RESULT = {remainder, quotient}, READY out)
// Build option:
//   DIV_ZERO_FAST_EN -- when defined, a zero divisor short-circuits through
//   BY_ZERO to END and returns RESULT = 0 two edges after START. When not
//   defined, a zero divisor runs the normal 32-step path.
// -----------------------------------------------------------------------------
module div
    import div_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    div_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    div_state_t       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [DIV_W-1:0] rem_q,    rem_d;
    logic [DIV_W-1:0] quo_q,    quo_d;
    logic [DIV_W-1:0] dvs_q,    dvs_d;
    logic             signed_q, signed_d;
    logic             a_neg_q,  a_neg_d;
    logic             b_neg_q,  b_neg_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             ready_q,  ready_d;

    logic [DIV_W-1:0] rem_nx, quo_nx;
    logic             a_neg_in, b_neg_in;
    logic [DIV_W-1:0] quo_fix, rem_fix;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    // Operand signs only count in signed mode.
    assign a_neg_in = bus.SIGNED_DIV & bus.DIVIDEND[DIV_W-1];
    assign b_neg_in = bus.SIGNED_DIV & bus.DIVISOR[DIV_W-1];

    // Sign correction: quotient negative when signs differ, remainder follows
    // the dividend. MIN / -1 yields magnitude 0x80000000, whose negation is
    // itself, so the overflow case needs no special handling.
    assign quo_fix = abs_val(quo_q, signed_q & (a_neg_q ^ b_neg_q));
    assign rem_fix = abs_val(rem_q, signed_q & a_neg_q);

    // NOTE: every value written below is given a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        signed_d = signed_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        result_d = result_q;
        ready_d  = 1'b0;

        unique case (state_q)
            FREE: begin
                if (bus.START && !bus.CANCEL) begin
                    signed_d = bus.SIGNED_DIV;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    rem_d    = '0;
                    quo_d    = abs_val(bus.DIVIDEND, a_neg_in);
                    dvs_d    = abs_val(bus.DIVISOR,  b_neg_in);
                    cnt_d    = '0;
`ifdef DIV_ZERO_FAST_EN
                    state_d  = (bus.DIVISOR == '0) ? BY_ZERO : ON;
`else
                    state_d  = ON;
`endif
                end
            end

            ON: begin
                if (bus.CANCEL) begin
                    state_d = FREE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = END;
                    end
                end
            end

            BY_ZERO: begin
                if (bus.CANCEL) begin
                    state_d = FREE;
                end else begin
`ifdef DIV_ZERO_FAST_EN
                    // Zero magnitudes make the sign fix in END produce 0.
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = END;
`else
                    state_d = FREE;
`endif
                end
            end

            END: begin
                state_d = FREE;
                if (!bus.CANCEL) begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end

            default: state_d = FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            signed_q <= signed_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.READY  = ready_q;

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for div. Directed corner cases followed by
// randomized operations, each compared against an arithmetic reference.
// Honours DIV_ZERO_FAST_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_div;
    import div_pkg::*;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    logic [RES_W-1:0] last_res;

    div_if bus ();

    div dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncated to 32-bit fields.
    // Division truncates toward zero and % takes the dividend's sign.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts an operation (caller is #1 after a rising edge), counts edges
    // until READY, checks latency, result and pulse width. With hold set,
    // START stays high and the operands change while the divider is busy.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit hold, input bit chk_val);
        int          n;
        bit          seen;
        int          exp_lat;
        logic [63:0] exp;
        exp     = model(s, a, b);
        exp_lat = (FAST && b == 32'd0) ? 2 : 33;
        bus.SIGNED_DIV = s;
        bus.DIVIDEND   = a;
        bus.DIVISOR    = b;
        bus.START      = 1'b1;
        @(posedge CLK); #1;
        if (hold) begin
            bus.SIGNED_DIV = ~s;
            bus.DIVIDEND   = ~a;
            bus.DIVISOR    = b + 32'd3;
        end else begin
            bus.START = 1'b0;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (n == 20) bus.START = 1'b0;
            seen = bus.READY;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (seen && chk_val) begin
            check({tag, "_res"}, bus.RESULT, exp);
        end
        if (chk_val) last_res = exp;
        @(posedge CLK); #1;
        check({tag, "_pulse"}, 64'(bus.READY), 64'd0);
    endtask

    task automatic idle_check(input string tag, input int cycles, input logic [63:0] exp_res);
        bit any;
        any = 1'b0;
        repeat (cycles) begin
            @(posedge CLK); #1;
            if (bus.READY) any = 1'b1;
        end
        check({tag, "_noready"}, 64'(any), 64'd0);
        check({tag, "_hold"}, bus.RESULT, exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        bit          rs;

        RST            = 1'b1;
        bus.SIGNED_DIV = 1'b0;
        bus.DIVIDEND   = '0;
        bus.DIVISOR    = '0;
        bus.START      = 1'b0;
        bus.CANCEL     = 1'b0;
        last_res       = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready",  64'(bus.READY), 64'd0);
        check("rst_result", bus.RESULT, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Directed cases with hand-derived expectations.
        run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
        check("u100_7_const", bus.RESULT, {32'h0000_0002, 32'h0000_000E});
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
        check("s_m7_2_const", bus.RESULT, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("u_max_1_const", bus.RESULT, {32'h0000_0000, 32'hFFFF_FFFF});
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("s_min_m1_const", bus.RESULT, {32'h0000_0000, 32'h8000_0000});

        // START held high while busy: ignored, exactly one READY pulse.
        run_op("hold", 1'b0, 32'd1_000_000, 32'd37, 1'b1, 1'b1);
        idle_check("hold_after", 40, last_res);

        // CANCEL beats START in FREE.
        bus.DIVIDEND = 32'd50; bus.DIVISOR = 32'd5; bus.SIGNED_DIV = 1'b0;
        bus.START = 1'b1; bus.CANCEL = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0; bus.CANCEL = 1'b0;
        idle_check("cancel_prio", 40, last_res);

        // CANCEL after 10 steps, then an immediate 9/3.
        bus.DIVIDEND = 32'd12345; bus.DIVISOR = 32'd11; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        bus.CANCEL = 1'b1;
        @(posedge CLK); #1;
        bus.CANCEL = 1'b0;
        check("cancel_ready",  64'(bus.READY), 64'd0);
        check("cancel_result", bus.RESULT, last_res);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b1);
        check("u9_3_const", bus.RESULT, {32'd0, 32'd3});

        // Reset after 20 steps.
        bus.DIVIDEND = 32'hDEAD_BEEF; bus.DIVISOR = 32'd13; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst_ready",  64'(bus.READY), 64'd0);
        check("midrst_result", bus.RESULT, 64'd0);
        last_res = '0;
        idle_check("midrst_after", 40, last_res);

        // Zero divisor: fast path returns 0, otherwise only latency matters.
        run_op("zero", 1'b0, 32'd5, 32'd0, 1'b0, FAST);
        if (FAST) check("zero_const", bus.RESULT, 64'd0);

        // Randomized operations with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: ra = 32'd0;
                default: ;
            endcase
            if (rb == 32'd0) rb = 32'd7;
            run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
